// File: rtl/stream_fifo_mc_pkg.sv
// Shared types and helpers for the multi-channel clearable stream FIFO.
package stream_fifo_mc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISOLATE = 2'd1,
        CLEAR   = 2'd2
    } clr_state_e;

    // Width of a channel index; never zero so a single channel still has a port.
    function automatic int unsigned chan_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo_mc_chan.sv
// One channel: storage, wrap-bit pointers, fill level and the isolate-then-clear FSM.
module stream_fifo_mc_chan
    import stream_fifo_mc_pkg::*;
#(
    parameter int unsigned LOG_DEPTH = 3,
    parameter type         T         = logic [31:0]
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  T                   in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               pop_i,
    output T                   head_o,
    output logic               eligible_o,
    output logic [LOG_DEPTH:0] usage_o,
    output logic               clear_pending_o
);
    localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
    localparam int unsigned PW    = LOG_DEPTH + 1;

    T              mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    clr_state_e    state_q;
    logic          pending_q;
    logic          full, empty, push;

    assign full            = (wptr_q ^ rptr_q) == {1'b1, {LOG_DEPTH{1'b0}}};
    assign empty           = wptr_q == rptr_q;
    assign in_ready_o      = !full && (state_q == IDLE);
    assign push            = in_valid_i && in_ready_o;
    assign eligible_o      = !empty && (state_q == IDLE);
    assign usage_o         = wptr_q - rptr_q;
    assign head_o          = mem_q[rptr_q[LOG_DEPTH-1:0]];
    assign clear_pending_o = pending_q;

    // Traffic accepted on the cycle clear_i rises completes normally; CLEAR wipes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clear_i) begin
                        state_q   <= ISOLATE;
                        pending_q <= 1'b1;
                    end
                end
                ISOLATE: begin
                    state_q   <= CLEAR;
                    pending_q <= 1'b1;
                end
                CLEAR: begin
                    state_q   <= clear_i ? ISOLATE : IDLE;
                    pending_q <= clear_i;
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= 1'b0;
                end
            endcase

            if (state_q == CLEAR) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push)                 wptr_q <= wptr_q + PW'(1);
                if (pop_i && eligible_o)  rptr_q <= rptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[LOG_DEPTH-1:0]] <= in_data_i;
    end

endmodule

// File: rtl/stream_fifo_mc_clearable.sv
// N-channel clearable FIFO merged onto one tagged output by a round-robin arbiter.
// Define STREAM_FIFO_MC_SPILL_EN to route the output through a 2-entry spill register.
module stream_fifo_mc_clearable
    import stream_fifo_mc_pkg::*;
#(
    parameter int unsigned N_CHAN    = 4,
    parameter int unsigned LOG_DEPTH = 3,
    parameter int unsigned WIDTH     = 32,
    parameter type         T         = logic [WIDTH-1:0]
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_CHAN-1:0]                   clear_i,
    output logic [N_CHAN-1:0]                   clear_pending_o,
    input  T     [N_CHAN-1:0]                   in_data_i,
    input  logic [N_CHAN-1:0]                   in_valid_i,
    output logic [N_CHAN-1:0]                   in_ready_o,
    output logic [N_CHAN-1:0][LOG_DEPTH:0]      usage_o,
    output T                                    out_data_o,
    output logic [chan_idx_w(N_CHAN)-1:0]       out_chan_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i
);
    localparam int unsigned CW = chan_idx_w(N_CHAN);

    logic [N_CHAN-1:0] eligible, pop;
    T     [N_CHAN-1:0] head;
    logic [CW-1:0]     prio_q, prio_nxt, rr_chan, grant;
    logic              rr_found, take;

    for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
        stream_fifo_mc_chan #(
            .LOG_DEPTH (LOG_DEPTH),
            .T         (T)
        ) u_chan (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .clear_i         (clear_i[c]),
            .in_data_i       (in_data_i[c]),
            .in_valid_i      (in_valid_i[c]),
            .in_ready_o      (in_ready_o[c]),
            .pop_i           (pop[c]),
            .head_o          (head[c]),
            .eligible_o      (eligible[c]),
            .usage_o         (usage_o[c]),
            .clear_pending_o (clear_pending_o[c])
        );
    end

    // First eligible channel at or after the priority pointer.
    always_comb begin
        int unsigned   sel;
        logic [CW-1:0] sel_c;
        sel      = 0;
        sel_c    = '0;
        rr_found = 1'b0;
        rr_chan  = '0;
        for (int unsigned i = 0; i < N_CHAN; i++) begin
            sel   = (32'(prio_q) + i) % N_CHAN;
            sel_c = CW'(sel);
            if (!rr_found && eligible[sel_c]) begin
                rr_found = 1'b1;
                rr_chan  = sel_c;
            end
        end
    end

    assign prio_nxt = (grant == CW'(N_CHAN - 1)) ? '0 : grant + CW'(1);

    always_comb begin
        pop = '0;
        for (int unsigned c = 0; c < N_CHAN; c++) begin
            pop[c] = take && (grant == CW'(c));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   prio_q <= '0;
        else if (take) prio_q <= prio_nxt;
    end

`ifdef STREAM_FIFO_MC_SPILL_EN
    // Beats in the spill register are committed; channel clears no longer reach them.
    T              sp_data_q [2];
    logic [CW-1:0] sp_chan_q [2];
    logic          sp_wr_q, sp_rd_q;
    logic [1:0]    sp_cnt_q;
    logic          deq;

    assign grant       = rr_chan;
    assign take        = rr_found && (sp_cnt_q != 2'd2);
    assign out_valid_o = sp_cnt_q != 2'd0;
    assign out_data_o  = sp_data_q[sp_rd_q];
    assign out_chan_o  = sp_chan_q[sp_rd_q];
    assign deq         = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_wr_q  <= 1'b0;
            sp_rd_q  <= 1'b0;
            sp_cnt_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                sp_data_q[i] <= '0;
                sp_chan_q[i] <= '0;
            end
        end else begin
            if (take) begin
                sp_data_q[sp_wr_q] <= head[grant];
                sp_chan_q[sp_wr_q] <= grant;
                sp_wr_q            <= !sp_wr_q;
            end
            if (deq) sp_rd_q <= !sp_rd_q;
            sp_cnt_q <= sp_cnt_q + {1'b0, take} - {1'b0, deq};
        end
    end
`else
    // A stalled beat keeps its grant; if its channel is isolated the lock simply lapses.
    logic          lock_q, lock_hit;
    logic [CW-1:0] lock_chan_q;

    assign lock_hit    = lock_q && eligible[lock_chan_q];
    assign grant       = lock_hit ? lock_chan_q : rr_chan;
    assign out_valid_o = lock_hit || rr_found;
    assign out_data_o  = head[grant];
    assign out_chan_o  = grant;
    assign take        = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
        end else begin
            lock_q      <= out_valid_o && !out_ready_i;
            lock_chan_q <= grant;
        end
    end
`endif

endmodule
